p1_loop_ctrl: RTL
=================

P1_LOOP_CTRL -- requirements
Module: p1_loop_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, width of the P1 index, N and PO1.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  begin a run; sampled only in IDLE.
REQ-005 N  input  WIDTH  last outer index; captured on an accepted start.
REQ-006 CO2  input  1  carry-out from the P2 register (register_8bit_P2); signals end of the inner loop.
REQ-007 PO1  output  WIDTH  current outer index; drives the P2 register's parallel load input PI1.
REQ-008 inzP2  output  1  zero-initialise P2.
REQ-009 incLd  output  1  load P2 from PO1.
REQ-010 incP2  output  1  increment P2.
REQ-011 step  output  1  one-cycle pulse per inner iteration, for the datapath.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, INIT, LOAD, INNER, NEXT, DONE; all outputs are Moore, except incP2 and step, which also depend on CO2.
REQ-015 IDLE: all control outputs low; on start=1: capture N, go to INIT; otherwise stay.
REQ-016 INIT (1 cycle): inzP2=1; P1 <= 0; go to LOAD.
REQ-017 LOAD (1 cycle): incLd=1 with PO1 stable; go to INNER.
REQ-018 INNER, CO2=0: incP2=1 and step=1; stay in INNER.
REQ-019 INNER, CO2=1: incP2=0 and step=0; go to NEXT; no increment is issued in the carry cycle.
REQ-020 NEXT (1 cycle): if P1 == captured N, go to DONE; else P1 <= P1+1 and go to LOAD.
REQ-021 DONE (1 cycle): done=1; go to IDLE; PO1 holds its last value until the next INIT.
REQ-022 The compare precedes the increment, so N=255 (WIDTH=8) terminates with no P1 wrap; N=0 executes exactly one outer pass.
REQ-023 The control outputs inzP2, incLd and incP2 are mutually exclusive in every cycle.
REQ-024 start while busy is ignored; a change of the N input while busy has no effect.
REQ-025 CO2 is ignored outside INNER.
REQ-026 Run length in cycles from accepted start to the done cycle inclusive = 1 + sum over passes of (3 + k_i), where k_i is the number of incP2 cycles in pass i.

Reset
REQ-027 rst=1 at a clock edge forces IDLE, P1=0, captured N=0, all outputs low, regardless of state, including mid-run.
REQ-028 rst has priority over start; start is honoured on the first edge after rst deasserts.

Structure
REQ-029 A shared package p1_loop_pkg holds the state enum type and the default WIDTH constant.
REQ-030 The P1 index is a sub-module counter_P1 (WIDTH bits, zero-init and increment, no carry needed), instantiated once.
REQ-031 The FSM is a single registered state plus combinational output decode; no latches.

Verification
REQ-032 Nominal run: N=2; the bench model asserts CO2 in the cycle after the 3rd incP2 of each pass -> PO1 sequence 0,1,2; incLd 3 pulses; step 9 pulses; done at cycle 1+3*(3+3)=19 after start.
REQ-033 N=0, CO2 asserted immediately on entering INNER -> zero incP2 pulses, one incLd, done 4 cycles after start, PO1=0.
REQ-034 N=255 with integration against the real P2 register: P2 loads PO1 and CO2 fires at 255 -> exactly 256 passes; PO1 ends at 255, no wrap; done pulses once.
REQ-035 Reset mid-run: rst during INNER of pass 1 -> next cycle IDLE, PO1=0, busy=0; a new start with N=1 completes normally.
REQ-036 start pulses and N changes injected while busy -> no effect on the PO1 sequence or on done timing; a start in the same cycle as rst is ignored.

Source files
------------

// File: rtl/p1_loop_pkg.sv
// Shared definitions for the P1 outer-loop controller: FSM state encoding
// and the default index width.
package p1_loop_pkg;

  localparam int P1_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    LOAD  = 3'd2,
    INNER = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } loop_state_e;

endpackage

// File: rtl/p1_loop_ctrl_counter.sv
// P1 outer-loop index register: clear-to-zero has priority over increment.
module counter_P1
  import p1_loop_pkg::*;
#(
  parameter int WIDTH = P1_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zero_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (zero_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/p1_loop_ctrl.sv
// Outer-loop controller: sequences P2 init/load/increment for each P1 index
// from 0 up to the captured N, with the end-of-pass compare ahead of the increment.
module p1_loop_ctrl
  import p1_loop_pkg::*;
#(
  parameter int WIDTH = P1_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic             CO2,
  output logic [WIDTH-1:0] PO1,
  output logic             inzP2,
  output logic             incLd,
  output logic             incP2,
  output logic             step,
  output logic             busy,
  output logic             done
);

  loop_state_e      state_q;
  loop_state_e      state_d;
  logic [WIDTH-1:0] nCap_q;
  logic [WIDTH-1:0] nCap_d;
  logic             p1Zero;
  logic             p1Inc;
  logic             lastPass;

  counter_P1 #(.WIDTH(WIDTH)) u_counter_P1 (
    .clk     (clk),
    .rst     (rst),
    .zero_i  (p1Zero),
    .inc_i   (p1Inc),
    .count_o (PO1)
  );

  assign lastPass = (PO1 == nCap_q);
  assign p1Zero   = (state_q == INIT);
  assign p1Inc    = (state_q == NEXT) && !lastPass;

  always_comb begin
    state_d = state_q;
    nCap_d  = nCap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          nCap_d  = N;
          state_d = INIT;
        end
      end
      INIT:    state_d = LOAD;
      LOAD:    state_d = INNER;
      INNER:   state_d = CO2 ? NEXT : INNER;
      NEXT:    state_d = lastPass ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      nCap_q  <= '0;
    end else begin
      state_q <= state_d;
      nCap_q  <= nCap_d;
    end
  end

  // incP2/step drop in the carry cycle so P2 is never stepped past its terminal value.
  always_comb begin
    inzP2 = (state_q == INIT);
    incLd = (state_q == LOAD);
    incP2 = (state_q == INNER) && !CO2;
    step  = (state_q == INNER) && !CO2;
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
  end

endmodule
